// File: rtl/vga_frame_receiver_if.sv
// rtl/vga_frame_receiver_if.sv - VGA sink video input and pixel report bundle
interface vga_frame_receiver_if;
    logic        pix_en;
    logic        hor_sync;
    logic        ver_sync;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        line_err;
    logic        frame_err;
    logic [7:0]  err_count;

    modport master (
        output pix_en, hor_sync, ver_sync, red, green, blue,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
        input  line_err, frame_err, err_count
    );

    modport slave (
        input  pix_en, hor_sync, ver_sync, red, green, blue,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
        output line_err, frame_err, err_count
    );
endinterface

// File: rtl/vga_frame_receiver.sv
// rtl/vga_frame_receiver.sv - VGA timing checker that locks and reports visible pixels
module vga_frame_receiver #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_frame_receiver_if.slave  vid
);
    localparam logic [9:0] H_TOTAL_C = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [9:0] H_LAST_C  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_START_C = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END_C   = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_TOTAL_C = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [9:0] V_LAST_C  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_START_C = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END_C   = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic       ACT       = (SYNC_ACTIVE != 0);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        hedge, vedge, checking, err;

    always_comb begin
        hedge     = vid.pix_en && (vid.hor_sync == ACT) && (hs_prev_q != ACT);
        // vsync is only judged at line starts, so its history advances on H-edges
        vedge     = hedge && (vid.ver_sync == ACT) && (vs_prev_q != ACT);
        hs_prev_d = vid.pix_en ? vid.hor_sync : hs_prev_q;
        vs_prev_d = hedge ? vid.ver_sync : vs_prev_q;

        hcnt_d = hcnt_q;
        if (hedge)
            hcnt_d = '0;
        else if (vid.pix_en && hcnt_q != H_TOTAL_C)
            hcnt_d = hcnt_q + 10'd1;

        vcnt_d = vcnt_q;
        if (vedge)
            vcnt_d = '0;
        else if (hedge && vcnt_q != V_TOTAL_C)
            vcnt_d = vcnt_q + 10'd1;

        checking    = (state_q != SEARCH);
        line_err_d  = checking && vid.pix_en &&
                      (hedge ? (hcnt_q != H_LAST_C) : (hcnt_q == H_LAST_C));
        frame_err_d = checking && hedge &&
                      (vedge ? (vcnt_q != V_LAST_C) : (vcnt_q == V_LAST_C));
        err         = line_err_d || frame_err_d;

        // an erroring V-edge never advances the search, a fresh one is required
        state_d = state_q;
        case (state_q)
            SEARCH:  if (vedge) state_d = VERIFY;
            VERIFY:  if (err) state_d = SEARCH; else if (vedge) state_d = LOCKED;
            LOCKED:  if (err) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
        locked_d = (state_d == LOCKED);

        pix_valid_d   = locked_d && vid.pix_en &&
                        (hcnt_d >= H_START_C) && (hcnt_d < H_END_C) &&
                        (vcnt_d >= V_START_C) && (vcnt_d < V_END_C);
        pix_x_d       = pix_valid_d ? (hcnt_d - H_START_C) : pix_x_q;
        pix_y_d       = pix_valid_d ? (vcnt_d - V_START_C) : pix_y_q;
        pix_rgb_d     = pix_valid_d ? {vid.red, vid.green, vid.blue} : pix_rgb_q;
        frame_start_d = pix_valid_d && (hcnt_d == H_START_C) && (vcnt_d == V_START_C);
        err_count_d   = (err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEARCH;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hs_prev_q     <= ~ACT;
            vs_prev_q     <= ~ACT;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign vid.pix_valid   = pix_valid_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.pix_rgb     = pix_rgb_q;
    assign vid.frame_start = frame_start_q;
    assign vid.locked      = locked_q;
    assign vid.line_err    = line_err_q;
    assign vid.frame_err   = frame_err_q;
    assign vid.err_count   = err_count_q;
endmodule

// File: tb/tb_vga_frame_receiver.sv
// tb/tb_vga_frame_receiver.sv - directed bench for vga_frame_receiver on a reduced raster
module tb_vga_frame_receiver;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 2;
    localparam int HT = 15, HST = 5, VT = 9, VST = 4;
    localparam logic ACT = 1'b0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_frame_receiver_if vif();

    vga_frame_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vid(vif)
    );

    int total = 0;
    int bad = 0;
    int gap = 1;
    int vedges_sent = 0;
    int n_valid, n_valid_unlocked, n_rgb_bad, n_fs, n_fs_bad;
    int n_lerr, n_ferr, n_both, lock_at, last_x, last_y;
    logic lk_after_err, prev_lerr = 1'b0, locked_prev = 1'b0;

    always @(negedge clk) begin
        if (vif.pix_valid) begin
            n_valid++;
            if (!vif.locked) n_valid_unlocked++;
            if (vif.pix_rgb !== {vif.pix_x[7:0], vif.pix_y[7:0], 8'hA5}) n_rgb_bad++;
            last_x = int'(vif.pix_x);
            last_y = int'(vif.pix_y);
        end
        if (vif.frame_start) begin
            n_fs++;
            if (!(vif.pix_valid && vif.pix_x == 10'd0 && vif.pix_y == 10'd0)) n_fs_bad++;
        end
        if (vif.line_err) n_lerr++;
        if (vif.frame_err) n_ferr++;
        if (vif.line_err && vif.frame_err) n_both++;
        if (vif.locked && !locked_prev) lock_at = vedges_sent;
        if (prev_lerr) lk_after_err = vif.locked;
        prev_lerr   = vif.line_err;
        locked_prev = vif.locked;
    end

    task automatic clear_stats();
        n_valid = 0; n_valid_unlocked = 0; n_rgb_bad = 0; n_fs = 0; n_fs_bad = 0;
        n_lerr = 0; n_ferr = 0; n_both = 0; lock_at = -1; last_x = -1; last_y = -1;
        lk_after_err = 1'b1; vedges_sent = 0;
    endtask

    task automatic send_pixel(input logic hs, input logic vs, input logic [23:0] rgb);
        vif.hor_sync = hs;
        vif.ver_sync = vs;
        {vif.red, vif.green, vif.blue} = rgb;
        vif.pix_en = 1'b1;
        @(posedge clk); #1;
        vif.pix_en = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_line(input int l, input int len, input int hs_w, input bit vs_en);
        logic hs, vs;
        logic [23:0] rgb;
        logic [7:0] xb, yb;
        for (int p = 0; p < len; p++) begin
            hs  = (p < hs_w) ? ACT : ~ACT;
            vs  = (vs_en && l < VS) ? ACT : ~ACT;
            rgb = '0;
            if (p >= HST && p < HST + HV && l >= VST && l < VST + VV) begin
                xb  = 8'(p - HST);
                yb  = 8'(l - VST);
                rgb = {xb, yb, 8'hA5};
            end
            if (p == 0 && l == 0 && vs_en) vedges_sent++;
            send_pixel(hs, vs, rgb);
        end
    endtask

    task automatic send_frame(input int nlines, input bit vs_en, input int short_l, input int short_len);
        for (int l = 0; l < nlines; l++)
            send_line(l, (l == short_l) ? short_len : HT, HS, vs_en);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vif.pix_en = 1'b0; vif.hor_sync = ~ACT; vif.ver_sync = ~ACT;
        vif.red = '0; vif.green = '0; vif.blue = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (vif.locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", vif.locked); end
        total++;
        if (vif.err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count: got %0d want 0", vif.err_count); end
        total++;
        if ({vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_rgb, vif.frame_start, vif.line_err, vif.frame_err} !== 49'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0",
                {vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_rgb, vif.frame_start, vif.line_err, vif.frame_err});
        end
    endtask

    task automatic test_nominal_lock();
        clear_stats();
        send_frame(VT, 1'b1, -1, 0);
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (lock_at !== 2) begin bad++; $display("FAIL lock_vedge: got %0d want 2", lock_at); end
        total++;
        if (n_valid !== HV * VV) begin bad++; $display("FAIL frame2_pixels: got %0d want %0d", n_valid, HV * VV); end
        n_valid = 0; n_fs = 0;
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (n_valid !== HV * VV) begin bad++; $display("FAIL frame3_pixels: got %0d want %0d", n_valid, HV * VV); end
        total++;
        if (n_fs !== 1) begin bad++; $display("FAIL frame3_start: got %0d want 1", n_fs); end
        total++;
        if (vif.err_count !== 8'd0 || n_lerr + n_ferr !== 0) begin
            bad++; $display("FAIL nominal_errors: got cnt=%0d pulses=%0d want 0", vif.err_count, n_lerr + n_ferr);
        end
        total++;
        if (vif.locked !== 1'b1) begin bad++; $display("FAIL nominal_locked: got %b want 1", vif.locked); end
    endtask

    task automatic test_mapping();
        clear_stats();
        gap = 3;
        send_frame(VT, 1'b1, -1, 0);
        gap = 1;
        total++;
        if (n_valid !== HV * VV) begin bad++; $display("FAIL map_pixels: got %0d want %0d", n_valid, HV * VV); end
        total++;
        if (n_rgb_bad !== 0) begin bad++; $display("FAIL map_rgb: got %0d bad pixels want 0", n_rgb_bad); end
        total++;
        if (n_fs !== 1 || n_fs_bad !== 0) begin bad++; $display("FAIL map_frame_start: got %0d/%0d want 1/0", n_fs, n_fs_bad); end
        total++;
        if (last_x !== HV - 1 || last_y !== VV - 1) begin
            bad++; $display("FAIL map_last: got (%0d,%0d) want (%0d,%0d)", last_x, last_y, HV - 1, VV - 1);
        end
    endtask

    task automatic test_short_line();
        clear_stats();
        send_frame(VT, 1'b1, 5, HT - 1);
        send_frame(VT, 1'b1, -1, 0);
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (n_lerr !== 1 || n_ferr !== 0) begin bad++; $display("FAIL short_pulses: got l=%0d f=%0d want 1/0", n_lerr, n_ferr); end
        total++;
        if (lk_after_err !== 1'b0) begin bad++; $display("FAIL short_unlock: got %b want 0", lk_after_err); end
        total++;
        if (lock_at !== 3) begin bad++; $display("FAIL short_relock: got %0d want 3", lock_at); end
        total++;
        if (vif.err_count !== 8'd1) begin bad++; $display("FAIL short_err_count: got %0d want 1", vif.err_count); end
        total++;
        if (n_valid !== 6 * HV) begin bad++; $display("FAIL short_pixels: got %0d want %0d", n_valid, 6 * HV); end
    endtask

    task automatic test_missing_vsync();
        clear_stats();
        send_frame(VT, 1'b0, -1, 0);
        total++;
        if (n_ferr !== 1 || n_lerr !== 0) begin bad++; $display("FAIL novs_pulses: got f=%0d l=%0d want 1/0", n_ferr, n_lerr); end
        total++;
        if (vif.locked !== 1'b0) begin bad++; $display("FAIL novs_unlocked: got %b want 0", vif.locked); end
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (n_valid !== 0) begin bad++; $display("FAIL novs_no_pixels: got %0d want 0", n_valid); end
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (lock_at !== 2 || n_valid !== HV * VV) begin
            bad++; $display("FAIL novs_relock: got lock=%0d pix=%0d want 2/%0d", lock_at, n_valid, HV * VV);
        end
        total++;
        if (vif.err_count !== 8'd2) begin bad++; $display("FAIL novs_err_count: got %0d want 2", vif.err_count); end
    endtask

    task automatic test_double_error();
        clear_stats();
        send_frame(4, 1'b1, 3, HT - 1);
        send_frame(VT, 1'b1, -1, 0);
        send_frame(VT, 1'b1, -1, 0);
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (n_both !== 1 || n_lerr !== 1 || n_ferr !== 1) begin
            bad++; $display("FAIL double_pulses: got both=%0d l=%0d f=%0d want 1/1/1", n_both, n_lerr, n_ferr);
        end
        total++;
        if (vif.err_count !== 8'd3) begin bad++; $display("FAIL double_err_count: got %0d want 3", vif.err_count); end
        total++;
        if (lock_at !== 4) begin bad++; $display("FAIL double_relock: got %0d want 4", lock_at); end
    endtask

    task automatic test_reset_mid_frame();
        clear_stats();
        for (int l = 0; l < 6; l++) send_line(l, HT, HS, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({vif.locked, vif.err_count, vif.pix_x, vif.pix_y, vif.pix_rgb} !== 53'd0) begin
            bad++; $display("FAIL midrst_outputs: got %h want 0", {vif.locked, vif.err_count, vif.pix_x, vif.pix_y, vif.pix_rgb});
        end
        for (int l = 6; l < VT; l++) send_line(l, HT, HS, 1'b1);
        clear_stats();
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (n_valid !== 0) begin bad++; $display("FAIL midrst_no_pixels: got %0d want 0", n_valid); end
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (lock_at !== 2 || n_valid !== HV * VV || n_valid_unlocked !== 0) begin
            bad++; $display("FAIL midrst_relock: got lock=%0d pix=%0d want 2/%0d", lock_at, n_valid, HV * VV);
        end
        total++;
        if (vif.err_count !== 8'd0) begin bad++; $display("FAIL midrst_err_count: got %0d want 0", vif.err_count); end
    endtask

    task automatic test_saturation();
        clear_stats();
        for (int i = 0; i < 520; i++) send_line((i % 2 == 0) ? 0 : VS, 3, 1, 1'b1);
        total++;
        if (n_lerr !== 260 || n_ferr !== 0) begin bad++; $display("FAIL sat_pulses: got l=%0d f=%0d want 260/0", n_lerr, n_ferr); end
        total++;
        if (vif.err_count !== 8'd255) begin bad++; $display("FAIL sat_err_count: got %0d want 255", vif.err_count); end
        clear_stats();
        send_frame(VT, 1'b1, -1, 0);
        send_frame(VT, 1'b1, -1, 0);
        total++;
        if (lock_at !== 2 || n_valid !== HV * VV) begin
            bad++; $display("FAIL sat_recover: got lock=%0d pix=%0d want 2/%0d", lock_at, n_valid, HV * VV);
        end
        total++;
        if (vif.err_count !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", vif.err_count); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_nominal_lock();
        test_mapping();
        test_short_line();
        test_missing_vsync();
        test_double_error();
        test_reset_mid_frame();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
